// File: rtl/trig_serializer.sv
// Trigger serializer: parallel trigger words enter a small FIFO and leave one bit per clk40 cycle
// on ser_out, framed by frame_start/frame_end, in free-running or on-demand mode.
module trig_serializer #(
    parameter int WORD_W    = 4,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit FREE_RUN  = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                       clk40,
    input  logic                       rst_n,
    input  logic [WORD_W-1:0]          din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic                       ser_out,
    output logic                       frame_start,
    output logic                       frame_end,
    output logic                       underflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
    localparam logic [WORD_W-1:0] IDLE_WORD = {WORD_W{IDLE_BIT}};

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [WORD_W-1:0] shreg_q, shreg_d, shifted;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              frame_start_q, frame_start_d;
    logic              underflow_q, underflow_d;
    logic              fifo_empty, push, pop, load;

    assign fifo_empty = (level_q == '0);
    assign din_ready  = (level_q < LVL_W'(DEPTH));
    assign push       = din_valid & din_ready;
    assign pop        = load & ~fifo_empty;

    assign shifted = MSB_FIRST ? {shreg_q[WORD_W-2:0], IDLE_BIT}
                               : {IDLE_BIT, shreg_q[WORD_W-1:1]};

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        frame_start_d = 1'b0;
        underflow_d   = 1'b0;
        load          = 1'b0;
        unique case (state_q)
            ST_IDLE: load = FREE_RUN || !fifo_empty;
            ST_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (FREE_RUN || !fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        shreg_d = IDLE_WORD;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    shreg_d   = shifted;
                end
            end
        endcase
        // An empty load only happens in free-running mode and sends an idle word.
        if (load) begin
            state_d       = ST_SHIFT;
            bit_cnt_d     = '0;
            shreg_d       = fifo_empty ? IDLE_WORD : mem_q[rd_ptr_q];
            frame_start_d = 1'b1;
            underflow_d   = fifo_empty;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= LAST_BIT;
            shreg_q       <= IDLE_WORD;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            level_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            level_q       <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: the word storage has no reset; resetting the level and pointers already invalidates it.
    always_ff @(posedge clk40) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign ser_out     = MSB_FIRST ? shreg_q[WORD_W-1] : shreg_q[0];
    assign frame_start = frame_start_q;
    assign frame_end   = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
    assign underflow   = underflow_q;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_trig_serializer.sv
// Bench for trig_serializer: three instances (on-demand MSB-first, free-running, 8-bit LSB-first)
// checked with a per-bit scoreboard, a FIFO-level vector table and hand-written frame sequences.
module tb_trig_serializer;

    logic clk40 = 1'b0;
    logic rst_n;
    always #5 clk40 = ~clk40;

    // a: WORD_W=4 MSB-first on-demand; b: WORD_W=4 free-running; c: WORD_W=8 LSB-first on-demand
    logic [3:0] din_a, din_b;
    logic [7:0] din_c;
    logic       din_valid_a, din_valid_b, din_valid_c;
    logic       din_ready_a, din_ready_b, din_ready_c;
    logic       ser_out_a, ser_out_b, ser_out_c;
    logic       frame_start_a, frame_start_b, frame_start_c;
    logic       frame_end_a, frame_end_b, frame_end_c;
    logic       underflow_a, underflow_b, underflow_c;
    logic [2:0] fifo_level_a, fifo_level_b, fifo_level_c;

    trig_serializer #(.WORD_W(4), .DEPTH(4), .MSB_FIRST(1'b1), .FREE_RUN(1'b0), .IDLE_BIT(1'b0)) dut_a (
        .clk40(clk40), .rst_n(rst_n), .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
        .ser_out(ser_out_a), .frame_start(frame_start_a), .frame_end(frame_end_a),
        .underflow(underflow_a), .fifo_level(fifo_level_a));

    trig_serializer #(.WORD_W(4), .DEPTH(4), .MSB_FIRST(1'b1), .FREE_RUN(1'b1), .IDLE_BIT(1'b0)) dut_b (
        .clk40(clk40), .rst_n(rst_n), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
        .ser_out(ser_out_b), .frame_start(frame_start_b), .frame_end(frame_end_b),
        .underflow(underflow_b), .fifo_level(fifo_level_b));

    trig_serializer #(.WORD_W(8), .DEPTH(4), .MSB_FIRST(1'b0), .FREE_RUN(1'b0), .IDLE_BIT(1'b0)) dut_c (
        .clk40(clk40), .rst_n(rst_n), .din(din_c), .din_valid(din_valid_c), .din_ready(din_ready_c),
        .ser_out(ser_out_c), .frame_start(frame_start_c), .frame_end(frame_end_c),
        .underflow(underflow_c), .fifo_level(fifo_level_c));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk40);
        #1;
    endtask

    // Scoreboards: expected serial bits in transmission order
    logic exp_a_q[$];
    logic exp_c_q[$];
    logic mon_en = 1'b0;
    int   a_idx  = -1;
    int   c_idx  = -1;

    task automatic sb_push_a(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) exp_a_q.push_back(w[i]);
    endtask

    task automatic sb_push_c(input logic [7:0] w);
        for (int i = 0; i < 8; i++) exp_c_q.push_back(w[i]);
    endtask

    task automatic a_push(input logic [3:0] w);
        check("a_push_ready", din_ready_a, 1'b1);
        din_a = w; din_valid_a = 1'b1; sb_push_a(w);
        tick();
        din_valid_a = 1'b0;
    endtask

    task automatic c_push(input logic [7:0] w);
        check("c_push_ready", din_ready_c, 1'b1);
        din_c = w; din_valid_c = 1'b1; sb_push_c(w);
        tick();
        din_valid_c = 1'b0;
    endtask

    always @(negedge clk40) begin
        if (!mon_en || !rst_n) begin
            a_idx = -1;
        end else begin
            if (frame_start_a) a_idx = 0;
            if (a_idx >= 0) begin
                if (exp_a_q.size() == 0) flag_fail("sb_a_unexpected_bit");
                else check("sb_a_bit", ser_out_a, exp_a_q.pop_front());
                check("sb_a_frame_end", frame_end_a, a_idx == 3);
                a_idx = (a_idx == 3) ? -1 : a_idx + 1;
            end else begin
                check("sb_a_idle", {frame_end_a, ser_out_a}, 2'b00);
            end
        end
    end

    always @(negedge clk40) begin
        if (!mon_en || !rst_n) begin
            c_idx = -1;
        end else begin
            if (frame_start_c) c_idx = 0;
            if (c_idx >= 0) begin
                if (exp_c_q.size() == 0) flag_fail("sb_c_unexpected_bit");
                else check("sb_c_bit", ser_out_c, exp_c_q.pop_front());
                check("sb_c_frame_end", frame_end_c, c_idx == 7);
                c_idx = (c_idx == 7) ? -1 : c_idx + 1;
            end else begin
                check("sb_c_idle", {frame_end_c, ser_out_c}, 2'b00);
            end
        end
    end

    typedef struct {
        logic       valid;
        logic [3:0] din;
        logic       exp_ready;
        logic [2:0] exp_level;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    logic [15:0] got_ser, got_fs, got_fe, got_uf;
    logic [11:0] fe_hist, uf_hist;
    logic        found;

    initial begin
        // FIFO fill/drain on dut_a: level and ready expected after each edge, input for the next edge
        vecs[0]  = '{1'b1, 4'hC, 1'b1, 3'd0};
        vecs[1]  = '{1'b1, 4'h3, 1'b1, 3'd1};
        vecs[2]  = '{1'b1, 4'h9, 1'b1, 3'd1};
        vecs[3]  = '{1'b1, 4'h6, 1'b1, 3'd2};
        vecs[4]  = '{1'b1, 4'hE, 1'b1, 3'd3};
        vecs[5]  = '{1'b1, 4'h5, 1'b0, 3'd4};
        vecs[6]  = '{1'b1, 4'h5, 1'b1, 3'd3};
        vecs[7]  = '{1'b0, 4'h0, 1'b0, 3'd4};
        vecs[8]  = '{1'b0, 4'h0, 1'b0, 3'd4};
        vecs[9]  = '{1'b0, 4'h0, 1'b0, 3'd4};
        vecs[10] = '{1'b0, 4'h0, 1'b1, 3'd3};

        rst_n = 1'b0;
        din_a = '0; din_b = '0; din_c = '0;
        din_valid_a = 1'b0; din_valid_b = 1'b0; din_valid_c = 1'b0;
        #12;
        check("rst_a_outs", {ser_out_a, frame_start_a, frame_end_a, underflow_a, din_ready_a}, 5'b00001);
        check("rst_b_outs", {ser_out_b, frame_start_b, frame_end_b, underflow_b, din_ready_b}, 5'b00001);
        check("rst_c_outs", {ser_out_c, frame_start_c, frame_end_c, underflow_c, din_ready_c}, 5'b00001);
        check("rst_levels", {fifo_level_a, fifo_level_b, fifo_level_c}, 9'd0);
        @(negedge clk40);
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // Single word 4'hA, on-demand: load one edge after the push, 4 bits, then idle
        a_push(4'hA);
        check("t2_level_after_push", fifo_level_a, 3'd1);
        check("t2_idle_before_load", {frame_start_a, ser_out_a}, 2'b00);
        tick();
        check("t2_bit0", {frame_start_a, frame_end_a, ser_out_a}, 3'b101);
        check("t2_level_after_load", fifo_level_a, 3'd0);
        tick();
        check("t2_bit1", {frame_start_a, frame_end_a, ser_out_a}, 3'b000);
        tick();
        check("t2_bit2", {frame_start_a, frame_end_a, ser_out_a}, 3'b001);
        tick();
        check("t2_bit3", {frame_start_a, frame_end_a, ser_out_a}, 3'b010);
        tick();
        check("t2_back_to_idle", {frame_start_a, frame_end_a, ser_out_a}, 3'b000);
        repeat (2) tick();

        // Two words back to back: 8 contiguous bits, frame markers every 4
        a_push(4'hA);
        a_push(4'h5);
        for (int i = 0; i < 8; i++) begin
            got_ser[7-i] = ser_out_a;
            got_fs[7-i]  = frame_start_a;
            got_fe[7-i]  = frame_end_a;
            tick();
        end
        check("t3_bits", got_ser[7:0], 8'b1010_0101);
        check("t3_frame_start", got_fs[7:0], 8'b1000_1000);
        check("t3_frame_end", got_fe[7:0], 8'b0001_0001);
        repeat (3) tick();

        // Six words into a 4-deep FIFO: ready drops at level 4, nothing lost
        for (int k = 0; k < NV; k++) begin
            check("t4_ready", din_ready_a, vecs[k].exp_ready);
            check("t4_level", fifo_level_a, vecs[k].exp_level);
            din_a = vecs[k].din;
            din_valid_a = vecs[k].valid;
            if (vecs[k].valid && vecs[k].exp_ready) sb_push_a(vecs[k].din);
            tick();
        end
        din_valid_a = 1'b0;
        repeat (24) tick();
        check("t4_drained_level", fifo_level_a, 3'd0);
        check("t4_sb_a_empty", exp_a_q.size(), 0);

        // 8-bit LSB-first: 8'h81 then 8'h02
        c_push(8'h81);
        c_push(8'h02);
        for (int i = 0; i < 16; i++) begin
            got_ser[15-i] = ser_out_c;
            got_fs[15-i]  = frame_start_c;
            got_fe[15-i]  = frame_end_c;
            tick();
        end
        check("t6_bits", got_ser, 16'b1000_0001_0100_0000);
        check("t6_frame_start", got_fs, 16'b1000_0000_1000_0000);
        check("t6_frame_end", got_fe, 16'b0000_0001_0000_0001);
        repeat (3) tick();
        check("t6_sb_c_empty", exp_c_q.size(), 0);

        // Free-running with an empty FIFO: idle frames, frame_end and underflow every 4 cycles
        for (int i = 0; i < 12; i++) begin
            check("t5_idle_ser", ser_out_b, 1'b0);
            fe_hist[i] = frame_end_b;
            uf_hist[i] = underflow_b;
            tick();
        end
        check("t5_fe_count", $countones(fe_hist), 3);
        check("t5_uf_count", $countones(uf_hist), 3);
        for (int i = 1; i < 12; i++) check("t5_uf_after_fe", uf_hist[i], fe_hist[i-1]);
        for (int i = 4; i < 12; i++) check("t5_fe_period", fe_hist[i], fe_hist[i-4]);

        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (frame_start_b) found = 1'b1;
            else tick();
        end
        if (!found) flag_fail("t5_frame_start_timeout");
        check("t5_ready", din_ready_b, 1'b1);
        din_b = 4'h3; din_valid_b = 1'b1;
        tick();
        din_valid_b = 1'b0;
        check("t5_level_after_push", fifo_level_b, 3'd1);
        for (int i = 0; i < 8; i++) begin
            got_ser[7-i] = ser_out_b;
            got_fs[7-i]  = frame_start_b;
            got_fe[7-i]  = frame_end_b;
            got_uf[7-i]  = underflow_b;
            tick();
        end
        check("t5_word_bits", got_ser[7:0], 8'b0000_0110);
        check("t5_word_frame_start", got_fs[7:0], 8'b0001_0001);
        check("t5_word_frame_end", got_fe[7:0], 8'b0010_0010);
        check("t5_word_underflow", got_uf[7:0], 8'b0000_0001);

        // Asynchronous reset in the middle of a frame with words still buffered
        a_push(4'hF);
        a_push(4'hF);
        a_push(4'hF);
        check("t1_pre_reset_bit", ser_out_a, 1'b1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_ser", ser_out_a, 1'b0);
        check("t1_async_level", fifo_level_a, 3'd0);
        check("t1_async_ready", din_ready_a, 1'b1);
        check("t1_async_frames", {frame_start_a, frame_end_a, frame_end_b, underflow_b}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_held_a", {ser_out_a, frame_start_a, frame_end_a}, 3'b000);
            check("t1_held_b", {ser_out_b, frame_start_b, frame_end_b, underflow_b}, 4'b0000);
        end
        exp_a_q.delete();
        @(negedge clk40);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t1_after_release_a", {ser_out_a, frame_start_a, frame_end_a, fifo_level_a}, 6'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
